// File: rtl/ni_packetizer.sv
// Transmit-side NI controller: pops {addr,data} entries from the write FIFO and
// sends each one to the router as a HEAD (addr) / TAIL (data) flit pair.
module ni_packetizer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [ADDR_W+DATA_W-1:0]   fifo_rd_data,
    output logic                       flit_valid,
    input  logic                       flit_ready,
    output logic [ADDR_W+1:0]          flit_data,
    output logic                       busy,
    output logic [CNT_W-1:0]           pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HEAD = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              fetch_ok;
    logic              tail_done;

    // A fetch is only legal when enabled, not in reset, and the FIFO has data.
    assign fetch_ok  = en & ~fifo_empty & ~reset;
    assign tail_done = (state_reg == TAIL) & flit_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == LOAD) begin
                addr_reg <= fifo_rd_data[ADDR_W+DATA_W-1:DATA_W];
                data_reg <= fifo_rd_data[DATA_W-1:0];
            end
            if (tail_done) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (fetch_ok) state_next = LOAD;
            LOAD: state_next = HEAD;
            HEAD: if (flit_ready) state_next = TAIL;
            TAIL: if (flit_ready) state_next = fetch_ok ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flit outputs depend only on the registered state, never on flit_ready.
    always_comb begin
        fifo_rd_en = 1'b0;
        flit_valid = 1'b0;
        flit_data  = '0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: fifo_rd_en = fetch_ok;
            HEAD: begin
                flit_valid = 1'b1;
                flit_data  = {TYPE_HEAD, addr_reg};
            end
            TAIL: begin
                flit_valid = 1'b1;
                flit_data  = {TYPE_TAIL, data_reg};
                fifo_rd_en = flit_ready & fetch_ok;
            end
            default: ;
        endcase
    end

    assign pkt_count = count_reg;

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: a packet-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_ni_packetizer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        rd_en2;
    logic [63:0] fifo_rd_data;
    logic        flit_valid;
    logic        flit_valid2;
    logic        flit_ready;
    logic [33:0] flit_data;
    logic [33:0] flit_data2;
    logic        busy;
    logic        busy2;
    logic [15:0] pkt_count;
    logic [1:0]  pkt_count2;

    ni_packetizer #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
        .busy(busy), .pkt_count(pkt_count)
    );

    // Narrow-counter copy sharing all inputs, used to observe counter wrap.
    ni_packetizer #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en2), .fifo_rd_data(fifo_rd_data),
        .flit_valid(flit_valid2), .flit_ready(flit_ready), .flit_data(flit_data2),
        .busy(busy2), .pkt_count(pkt_count2)
    );

    logic [63:0] fq[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;

    // Reference model: progress of the packet in flight (-1 none, 0 fetched,
    // 1 head offered, 2 tail offered) and packets completed since reset.
    int          stage = -1;
    bit          known = 1'b0;
    logic [63:0] pend;
    logic [63:0] cur;
    int          mcnt = 0;

    int          pop_cyc[$];
    int          hs_cyc[$];
    logic [33:0] hs_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        fq.push_back({a, d});
    endtask

    task automatic step();
        logic        exp_pop;
        logic        exp_valid;
        logic [33:0] exp_data;
        logic        dut_pop;
        logic [63:0] front;
        logic [63:0] popped;
        fifo_empty = (fq.size() == 0);
        #1;
        front     = (fq.size() > 0) ? fq[0] : 64'h0;
        exp_pop   = !reset && en && !fifo_empty && (stage == -1 || (stage == 2 && flit_ready));
        exp_valid = (stage >= 1);
        exp_data  = (stage == 1) ? {2'b01, cur[63:32]} : {2'b10, cur[31:0]};
        if (known) begin
            chk("rd_en", {63'h0, fifo_rd_en}, {63'h0, exp_pop});
            chk("rd_en_w2", {63'h0, rd_en2}, {63'h0, exp_pop});
            chk("flit_valid", {63'h0, flit_valid}, {63'h0, exp_valid});
            chk("busy", {63'h0, busy}, {63'h0, stage >= 0});
            if (exp_valid) chk("flit_data", {30'h0, flit_data}, {30'h0, exp_data});
            chk("pkt_count", {48'h0, pkt_count}, {48'h0, 16'(mcnt)});
            chk("pkt_count_w2", {62'h0, pkt_count2}, {62'h0, 2'(mcnt)});
        end
        dut_pop = fifo_rd_en;
        if (dut_pop) pop_cyc.push_back(cyc);
        if (flit_valid && flit_ready) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(flit_data);
            $display("cycle %0d: flit sent 0x%09h", cyc, flit_data);
        end
        popped = 64'h0;
        @(posedge clk);
        if (dut_pop && fq.size() > 0) popped = fq.pop_front();
        if (reset) begin
            stage = -1;
            mcnt  = 0;
            known = 1'b1;
        end else if (known) begin
            case (stage)
                -1: if (exp_pop) begin pend = front; stage = 0; end
                0: begin cur = pend; stage = 1; end
                1: if (flit_ready) stage = 2;
                2: if (flit_ready) begin
                    mcnt++;
                    if (exp_pop) begin pend = front; stage = 0; end
                    else stage = -1;
                end
                default: stage = -1;
            endcase
        end
        @(negedge clk);
        // FIFO read data appears in the cycle after the pop.
        if (dut_pop) fifo_rd_data = popped;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int pb;
    int hb;

    initial begin
        reset = 1'b1; en = 1'b1; flit_ready = 1'b0; fifo_rd_data = 64'h0;
        fifo_empty = 1'b0;
        push(32'h0BAD_0BAD, 32'h0BAD_0BAD);
        @(negedge clk);

        // Reset held with a non-empty FIFO and en=1.
        run(2);
        chk("t1_rd_en", {63'h0, fifo_rd_en}, 64'h0);
        chk("t1_valid", {63'h0, flit_valid}, 64'h0);
        chk("t1_busy", {63'h0, busy}, 64'h0);
        chk("t1_count", {48'h0, pkt_count}, 64'h0);
        chk("t1_data", {30'h0, flit_data}, 64'h0);
        fq.delete();
        reset = 1'b0; en = 1'b0;
        run(1);

        // Single packet.
        pb = pop_cyc.size(); hb = hs_cyc.size();
        en = 1'b1; flit_ready = 1'b1;
        push(32'hA5A5_A5A5, 32'hAAAA_AAAA);
        run(5);
        chk("t2_pops", 64'(pop_cyc.size() - pb), 64'd1);
        chk("t2_flits", 64'(hs_cyc.size() - hb), 64'd2);
        chk("t2_head", {30'h0, hs_data[hb]}, 64'h1_A5A5_A5A5);
        chk("t2_tail", {30'h0, hs_data[hb+1]}, 64'h2_AAAA_AAAA);
        chk("t2_tail_gap", 64'(hs_cyc[hb+1] - hs_cyc[hb]), 64'd1);
        chk("t2_latency", 64'(hs_cyc[hb] - pop_cyc[pb]), 64'd2);
        chk("t2_count", {48'h0, pkt_count}, 64'd1);
        chk("t2_busy", {63'h0, busy}, 64'h0);

        // Backpressure in HEAD.
        pb = pop_cyc.size();
        flit_ready = 1'b0;
        push(32'h0000_1111, 32'h0000_2222);
        run(7);
        chk("t3_valid", {63'h0, flit_valid}, 64'd1);
        chk("t3_data", {30'h0, flit_data}, 64'h1_0000_1111);
        chk("t3_pops", 64'(pop_cyc.size() - pb), 64'd1);
        flit_ready = 1'b1;
        run(1);
        chk("t3_to_tail", {30'h0, flit_data}, 64'h2_0000_2222);
        run(2);
        chk("t3_count", {48'h0, pkt_count}, 64'd2);

        // Back-to-back packets.
        pb = pop_cyc.size(); hb = hs_cyc.size();
        for (int i = 0; i < 3; i++) push(32'h1000_0000 + 32'(i), 32'hD000_0000 + 32'(i));
        run(12);
        chk("t4_pops", 64'(pop_cyc.size() - pb), 64'd3);
        chk("t4_flits", 64'(hs_cyc.size() - hb), 64'd6);
        chk("t4_span", 64'(hs_cyc[hb+5] - pop_cyc[pb]), 64'd9);
        chk("t4_last_tail", {30'h0, hs_data[hb+5]}, 64'h2_D000_0002);
        chk("t4_count", {48'h0, pkt_count}, 64'd5);

        // en dropped during HEAD with a second entry still queued.
        pb = pop_cyc.size();
        push(32'h2000_0000, 32'hE000_0000);
        push(32'h2000_0001, 32'hE000_0001);
        run(2);
        en = 1'b0;
        run(4);
        chk("t5_pops", 64'(pop_cyc.size() - pb), 64'd1);
        chk("t5_busy", {63'h0, busy}, 64'h0);
        chk("t5_left", 64'(fq.size()), 64'd1);
        chk("t5_count", {48'h0, pkt_count}, 64'd6);
        en = 1'b1;
        run(5);
        chk("t5_count2", {48'h0, pkt_count}, 64'd7);

        // Reset while TAIL is stalled, then counter wrap on the 2-bit copy.
        push(32'hDEAD_0001, 32'hBEEF_0001);
        run(3);
        flit_ready = 1'b0;
        run(2);
        chk("t6_tail_hold", {30'h0, flit_data}, 64'h2_BEEF_0001);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        chk("t6_valid", {63'h0, flit_valid}, 64'h0);
        chk("t6_busy", {63'h0, busy}, 64'h0);
        chk("t6_count", {48'h0, pkt_count}, 64'h0);
        flit_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(32'h3000_0000 + 32'(i), 32'hF000_0000 + 32'(i));
        run(17);
        chk("t6_count5", {48'h0, pkt_count}, 64'd5);
        chk("t6_wrap", {62'h0, pkt_count2}, 64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
